// File: rtl/lcd_spi_tx_pkg.sv
// Shared definitions for the ST7789V3 SPI transmit path: FSM state encodings,
// DC pin polarity and the default SCL half-period.
package lcd_spi_tx_pkg;

    typedef enum logic [2:0] {
        LCD_SPI_IDLE,
        LCD_SPI_SETUP,
        LCD_SPI_SHIFT_HI,
        LCD_SPI_SHIFT_LO,
        LCD_SPI_HOLD
    } lcd_spi_state_e;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int LCD_SPI_DEFAULT_DIV = 2;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_spi_tx_spi_phase_timer.sv
// Down-counter that times one SCL half-period: reloads to CLK_DIV-1 on load_i
// and flags phase_done_o while it sits at zero.
module spi_phase_timer
    import lcd_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = LCD_SPI_DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic phase_done_o
);

    localparam int DW = ctr_width(CLK_DIV + 1);
    localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_ctr_q, div_ctr_d;

    always_comb begin
        div_ctr_d = div_ctr_q;
        if (load_i) begin
            div_ctr_d = RELOAD;
        end else if (div_ctr_q != '0) begin
            div_ctr_d = div_ctr_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_ctr_q <= '0;
        end else begin
            div_ctr_q <= div_ctr_d;
        end
    end

    assign phase_done_o = (div_ctr_q == '0);

endmodule

// File: rtl/lcd_spi_tx.sv
// ST7789V3 4-wire SPI (mode 0) byte serialiser fed from the command FIFO.
// Define LCD_SPI_BURST_EN to chain back-to-back bytes under one CS_N frame.
module lcd_spi_tx
    import lcd_spi_tx_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int CLK_DIV    = LCD_SPI_DEFAULT_DIV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic                  is_cmd,
    output logic                  busy,
    output logic                  lcd_scl,
    output logic                  lcd_sda,
    output logic                  lcd_dc,
    output logic                  lcd_cs_n
);

    localparam int BW = ctr_width(WORD_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);

    lcd_spi_state_e        state_q;
    logic [WORD_WIDTH-1:0] sreg_q;
    logic [BW-1:0]         bit_ctr_q;
    logic                  scl_q, sda_q, dc_q, cs_n_q;
    logic                  phase_done, timer_load, burst_slot, take;

`ifdef LCD_SPI_BURST_EN
    // Last cycle of the final SCL-high phase: a new byte can slot straight in.
    assign burst_slot = (state_q == LCD_SPI_SHIFT_HI) && (bit_ctr_q == '0) && phase_done;
`else
    assign burst_slot = 1'b0;
`endif

    // take is the handshake as seen by the flops; rst only gates the port.
    assign take       = valid && ((state_q == LCD_SPI_IDLE) || burst_slot);
    assign ready      = rst && ((state_q == LCD_SPI_IDLE) || burst_slot);
    assign timer_load = take || ((state_q != LCD_SPI_IDLE) && phase_done);

    spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (timer_load),
        .phase_done_o (phase_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LCD_SPI_IDLE;
            sreg_q    <= '0;
            bit_ctr_q <= '0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
            dc_q      <= DC_DATA;
            cs_n_q    <= 1'b1;
        end else begin
            case (state_q)
                LCD_SPI_IDLE: begin
                    if (take) begin
                        state_q   <= LCD_SPI_SETUP;
                        sreg_q    <= data;
                        sda_q     <= data[WORD_WIDTH-1];
                        dc_q      <= is_cmd ? DC_CMD : DC_DATA;
                        bit_ctr_q <= LAST_BIT;
                        cs_n_q    <= 1'b0;
                    end
                end
                LCD_SPI_SETUP: begin
                    if (phase_done) begin
                        state_q <= LCD_SPI_SHIFT_HI;
                        scl_q   <= 1'b1;
                    end
                end
                LCD_SPI_SHIFT_HI: begin
                    if (phase_done) begin
                        scl_q <= 1'b0;
                        if (take) begin
                            // Chained byte: its bit7 goes out in this low phase.
                            state_q   <= LCD_SPI_SHIFT_LO;
                            sreg_q    <= data;
                            sda_q     <= data[WORD_WIDTH-1];
                            dc_q      <= is_cmd ? DC_CMD : DC_DATA;
                            bit_ctr_q <= LAST_BIT;
                        end else if (bit_ctr_q == '0) begin
                            state_q <= LCD_SPI_HOLD;
                        end else begin
                            state_q   <= LCD_SPI_SHIFT_LO;
                            sreg_q    <= sreg_q << 1;
                            sda_q     <= sreg_q[WORD_WIDTH-2];
                            bit_ctr_q <= bit_ctr_q - BW'(1);
                        end
                    end
                end
                LCD_SPI_SHIFT_LO: begin
                    if (phase_done) begin
                        state_q <= LCD_SPI_SHIFT_HI;
                        scl_q   <= 1'b1;
                    end
                end
                LCD_SPI_HOLD: begin
                    if (phase_done) begin
                        state_q <= LCD_SPI_IDLE;
                        cs_n_q  <= 1'b1;
                    end
                end
                default: state_q <= LCD_SPI_IDLE;
            endcase
        end
    end

    assign busy     = (state_q != LCD_SPI_IDLE);
    assign lcd_scl  = scl_q;
    assign lcd_sda  = sda_q;
    assign lcd_dc   = dc_q;
    assign lcd_cs_n = cs_n_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Randomised bench for lcd_spi_tx: three instances (CLK_DIV 1..3), each with a
// cycles-since-accept timeline model, a bus monitor and a random producer.
module tb_lcd_spi_tx;

    localparam int NL     = 3;
    localparam int IDLE_K = 100000;
`ifdef LCD_SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int lane, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s lane%0d: got %0d expected %0d at %0t", name, lane, act, exp, $time);
        end
    endtask

    genvar g;
    generate
        for (g = 0; g < NL; g++) begin : ln
            localparam int T     = g + 1;
            localparam int FLEN  = (g == 0) ? 17 : (g == 1) ? 34 : 51;
            localparam int SPACE = (g == 0) ? 18 : (g == 1) ? 35 : 52;

            logic       v, c, rdy, bsy, scl, sda, dc, csn;
            logic [7:0] d;

            lcd_spi_tx #(
                .WORD_WIDTH (8),
                .CLK_DIV    (T)
            ) dut (
                .clk      (clk),
                .rst      (rst),
                .valid    (v),
                .ready    (rdy),
                .data     (d),
                .is_cmd   (c),
                .busy     (bsy),
                .lcd_scl  (scl),
                .lcd_sda  (sda),
                .lcd_dc   (dc),
                .lcd_cs_n (csn)
            );

            logic [7:0] caset [5] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'hEF};
            logic       dcp   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

            // Model: k = cycles since the last accepted byte; everything on the
            // bus is a pure function of k, the byte and its flag.
            int         k = IDLE_K;
            logic [7:0] cur = 8'h00;
            logic       dc_m = 1'b1;
            logic [8:0] expq [$];
            logic       rdy_m;

            assign rdy_m = rst && ((k >= 17 * T) || (BURST && (k == 16 * T - 1)));

            always @(posedge clk or negedge rst) begin
                if (!rst) begin
                    k    <= IDLE_K;
                    dc_m <= 1'b1;
                    expq.delete();
                end else if (v && rdy_m) begin
                    k    <= 0;
                    cur  <= d;
                    dc_m <= ~c;
                    expq.push_back({c, d});
                end else if (k < IDLE_K) begin
                    k <= k + 1;
                end
            end

            always @(negedge clk) begin : cmp
                int p, j;
                bit fr, scl_e;
                if (rst) begin
                    fr    = (k < 17 * T);
                    p     = (fr && k >= T) ? (k - T) / T : -1;
                    scl_e = (p >= 0) && (p < 15) && (p % 2 == 0);
                    j     = (p < 0) ? 0 : (((p + 1) / 2 > 7) ? 7 : (p + 1) / 2);
                    chk("cs_n", g, csn, !fr);
                    chk("busy", g, bsy, fr);
                    chk("scl", g, scl, scl_e);
                    chk("dc", g, dc, dc_m);
                    chk("ready", g, rdy, rdy_m);
                    if (fr) chk("sda", g, sda, cur[7-j]);
                end else begin
                    chk("rst_cs_n", g, csn, 1);
                    chk("rst_scl", g, scl, 0);
                    chk("rst_sda", g, sda, 0);
                    chk("rst_dc", g, dc, 1);
                    chk("rst_busy", g, bsy, 0);
                    chk("rst_ready", g, rdy, 0);
                end
            end

            // Reset must take effect without waiting for a clock edge.
            always @(negedge rst) begin
                #1;
                chk("async_rst_cs_n", g, csn, 1);
                chk("async_rst_scl", g, scl, 0);
                chk("async_rst_ready", g, rdy, 0);
            end

            int         nbits = 0, flen = 0, nbyte = 0, nacc = 0, last_acc = 0, cyc = 0;
            logic [7:0] sh = 8'h00;
            logic       pscl = 1'b0, psda = 1'b0, pcs = 1'b1;

            always @(negedge clk) begin : mon
                logic [8:0] e;
                cyc++;
                if (!rst) begin
                    nbits = 0;
                    flen  = 0;
                    pscl  = 1'b0;
                    pcs   = 1'b1;
                end else begin
                    if (!csn) flen++;
                    if (scl && !pscl) begin
                        chk("sda_stable_at_rise", g, sda, psda);
                        sh = {sh[6:0], sda};
                        nbits++;
                        if (nbits == 8) begin
                            nbits = 0;
                            chk("bytes_pending", g, expq.size() > 0, 1);
                            if (expq.size() > 0) begin
                                e = expq.pop_front();
                                chk("bus_byte", g, sh, e[7:0]);
                                chk("bus_dc", g, dc, !e[8]);
                                if (nbyte < 5) begin
                                    chk("caset_byte", g, sh, caset[nbyte]);
                                    chk("caset_dc", g, dc, dcp[nbyte]);
                                end
                                nbyte++;
                            end
                        end
                    end
                    if (csn && !pcs) begin
                        chk("bits_at_frame_end", g, nbits, 0);
`ifndef LCD_SPI_BURST_EN
                        chk("frame_len", g, flen, FLEN);
`endif
                        flen = 0;
                    end
                    if (v && rdy) begin
`ifndef LCD_SPI_BURST_EN
                        if (nacc > 0 && nacc < 5) chk("accept_spacing", g, cyc - last_acc, SPACE);
`endif
                        last_acc = cyc;
                        nacc++;
                    end
                    pscl = scl;
                    psda = sda;
                    pcs  = csn;
                end
            end

            initial begin : prod
                v = 1'b0;
                d = 8'h00;
                c = 1'b0;
                @(posedge rst);
                @(posedge clk);
                #1;
                // CASET 0x2A then four parameters, valid never dropped.
                for (int i = 0; i < 5; i++) begin
                    v = 1'b1;
                    d = caset[i];
                    c = (i == 0);
                    do @(posedge clk); while (!rdy_m);
                    #1;
                end
                v = 1'b0;
                forever begin
                    if ($urandom_range(0, 2) == 0) begin
                        v = 1'b0;
                        repeat ($urandom_range(1, 20 * T)) @(posedge clk);
                        #1;
                    end
                    v = 1'b1;
                    d = 8'($urandom);
                    c = ($urandom_range(0, 3) == 0);
                    forever begin
                        @(posedge clk);
                        if (v && rdy_m) break;
                        #1;
                        v = ($urandom_range(0, 3) != 0);
                    end
                    #1;
                end
            end
        end
    endgenerate

    initial begin : main
        int n;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (1500) @(posedge clk);
        // Abort the CLK_DIV=2 lane during the SCL-high phase of its 4th bit.
        n = 0;
        #1;
        while (ln[1].k != 14 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reset_window_found", 1, n < 1000, 1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (1500) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
